expr_sweep_ctrl: RTL and testbench



---
 rtl/expr_pkg.sv | 21 ++
 rtl/expr_sweep_ctrl_if.sv | 27 ++
 rtl/expr_sweep_ctrl_settle_timer.sv | 27 ++
 rtl/expr_sweep_ctrl.sv | 141 ++++++++++++++
 tb/tb_expr_sweep_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/expr_pkg.sv
// Shared definitions for the expression-bank sweep sequencer: state encoding,
// Gray-order operand rows and truth-table indexing.
package expr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int TT_W = 4;

   // Rows are {x,y}; consecutive rows differ in one operand bit only.
   localparam logic [1:0] GRAY_ROWS [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   function automatic logic [1:0] tt_index(input logic x, input logic y);
      return {x, y};
   endfunction

endpackage

// File: rtl/expr_sweep_ctrl_if.sv
// Sweep bus between the sequencer and its consumer/expression bank.
// Handshake: a sweep is requested by start while not busy; it completes with a one-cycle done pulse, after which equiv/tt_a/tt_b are valid and held until the next accepted start.
interface expr_sweep_ctrl_if import expr_pkg::*; #(parameter int N_PAIRS = 4);

   logic                     start;
   logic                     abort;
   logic [N_PAIRS-1:0]       f_a;
   logic [N_PAIRS-1:0]       f_b;
   logic                     x;
   logic                     y;
   logic                     busy;
   logic                     done;
   logic [N_PAIRS-1:0]       equiv;
   logic [TT_W*N_PAIRS-1:0]  tt_a;
   logic [TT_W*N_PAIRS-1:0]  tt_b;

   modport master (
      output start, abort, f_a, f_b,
      input  x, y, busy, done, equiv, tt_a, tt_b
   );

   modport slave (
      input  start, abort, f_a, f_b,
      output x, y, busy, done, equiv, tt_a, tt_b
   );

endinterface

// File: rtl/expr_sweep_ctrl_settle_timer.sv
// Loadable down-counter holding the operands stable before each sample.
module settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/expr_sweep_ctrl.sv
// Walks x/y through the four Gray rows, samples every expression pair per row
// and accumulates both truth tables plus a per-pair equivalence verdict.
module expr_sweep_ctrl import expr_pkg::*; #(
   parameter int N_PAIRS = 4,
   parameter int SETTLE  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   expr_sweep_ctrl_if.slave   bus,
   output state_t             dbg_state
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

   state_t state_q, state_d;

   logic       row_load, ops_zero;
   logic [1:0] row_sel;
   logic       step_clr, step_inc;
   logic       init_results, clr_results, sample_en;
   logic       timer_load, timer_dec, timer_zero;

   logic                    x_q, y_q;
   logic [1:0]              step_q;
   logic [1:0]              sample_idx;
   logic [N_PAIRS-1:0]      equiv_q;
   logic [TT_W*N_PAIRS-1:0] tt_a_q, tt_b_q;

   settle_timer #(.W(4)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (SETTLE_LOAD),
      .dec      (timer_dec),
      .zero     (timer_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      row_load     = 1'b0;
      row_sel      = 2'd0;
      ops_zero     = 1'b0;
      step_clr     = 1'b0;
      step_inc     = 1'b0;
      init_results = 1'b0;
      clr_results  = 1'b0;
      sample_en    = 1'b0;
      timer_load   = 1'b0;
      timer_dec    = 1'b0;
      // abort overrides every transition, including a start in IDLE/DONE
      if (bus.abort) begin
         state_d     = ST_IDLE;
         clr_results = 1'b1;
         ops_zero    = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state_d      = ST_SETTLE;
                  row_load     = 1'b1;
                  row_sel      = 2'd0;
                  step_clr     = 1'b1;
                  init_results = 1'b1;
                  timer_load   = 1'b1;
               end else begin
                  state_d  = ST_IDLE;
                  ops_zero = 1'b1;
               end
            end
            ST_SETTLE: begin
               timer_dec = 1'b1;
               if (timer_zero) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
               sample_en = 1'b1;
               if (step_q != 2'd3) begin
                  state_d    = ST_SETTLE;
                  step_inc   = 1'b1;
                  row_load   = 1'b1;
                  row_sel    = step_q + 2'd1;
                  timer_load = 1'b1;
               end else begin
                  state_d  = ST_DONE;
                  ops_zero = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign sample_idx = tt_index(x_q, y_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q     <= 1'b0;
         y_q     <= 1'b0;
         step_q  <= 2'd0;
         equiv_q <= '0;
         tt_a_q  <= '0;
         tt_b_q  <= '0;
      end else begin
         if (row_load)      {x_q, y_q} <= GRAY_ROWS[row_sel];
         else if (ops_zero) {x_q, y_q} <= 2'b00;

         if (step_clr)      step_q <= 2'd0;
         else if (step_inc) step_q <= step_q + 2'd1;

         if (clr_results) begin
            equiv_q <= '0;
            tt_a_q  <= '0;
            tt_b_q  <= '0;
         end else if (init_results) begin
            equiv_q <= '1;
            tt_a_q  <= '0;
            tt_b_q  <= '0;
         end else if (sample_en) begin
            for (int i = 0; i < N_PAIRS; i++) begin
               tt_a_q[TT_W*i + int'(sample_idx)] <= bus.f_a[i];
               tt_b_q[TT_W*i + int'(sample_idx)] <= bus.f_b[i];
               if (bus.f_a[i] != bus.f_b[i]) equiv_q[i] <= 1'b0;
            end
         end
      end
   end

   assign bus.x     = x_q;
   assign bus.y     = y_q;
   assign bus.busy  = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
   assign bus.done  = (state_q == ST_DONE);
   assign bus.equiv = equiv_q;
   assign bus.tt_a  = tt_a_q;
   assign bus.tt_b  = tt_b_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_expr_sweep_ctrl.sv
// Bench for expr_sweep_ctrl: SETTLE=1 and SETTLE=3 instances driven by a
// model of the expression bank, results checked through an expected queue.
module tb_expr_sweep_ctrl;
   import expr_pkg::*;

   // {equiv, tt_a, tt_b}
   localparam logic [35:0] REAL_EXP = {4'b0110, 16'h1F7B, 16'h7F7C};
   localparam logic [35:0] STUB_EXP = {4'b1111, 16'hF0F0, 16'hF0F0};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic bank_real = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [35:0] exp_q[$];

   always #5 clk = ~clk;

   expr_sweep_ctrl_if #(.N_PAIRS(4)) bus1 ();
   expr_sweep_ctrl_if #(.N_PAIRS(4)) bus3 ();
   state_t dbg1, dbg3;

   expr_sweep_ctrl #(.N_PAIRS(4), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .dbg_state(dbg1));
   expr_sweep_ctrl #(.N_PAIRS(4), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .dbg_state(dbg3));

   // Bank pairs {e,d,c,b}; b is the term whose table is 1011 under {x,y} indexing.
   function automatic logic [3:0] bank_a(input logic x, input logic y);
      return {~(x | y), 1'b1, ~(x & y), ~x | y};
   endfunction
   function automatic logic [3:0] bank_b(input logic x, input logic y);
      return {~(x & y), 1'b1, ~(x & y), x};
   endfunction

   assign bus1.f_a = bank_real ? bank_a(bus1.x, bus1.y) : 4'b1010;
   assign bus1.f_b = bank_real ? bank_b(bus1.x, bus1.y) : 4'b1010;
   assign bus3.f_a = bank_a(bus3.x, bus3.y);
   assign bus3.f_b = bank_b(bus3.x, bus3.y);

   task automatic pop_and_compare(input logic [35:0] got, input string tag);
      logic [35:0] want;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s unexpected_done: got %h want no result", tag, got);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            failures++;
            $display("FAIL %s results: got %h want %h", tag, got, want);
         end
      end
   endtask

   task automatic check_queue_empty(input string tag);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s missing_done: got %0d pending want 0", tag, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({dbg1, bus1.x, bus1.y, bus1.busy, bus1.done} !== {ST_IDLE, 4'b0000}) begin
         failures++;
         $display("FAIL reset_ctrl1: got %b want %b", {dbg1, bus1.x, bus1.y, bus1.busy, bus1.done}, {ST_IDLE, 4'b0000});
      end
      checks++;
      if ({bus1.equiv, bus1.tt_a, bus1.tt_b} !== 36'h0) begin
         failures++;
         $display("FAIL reset_results1: got %h want 0", {bus1.equiv, bus1.tt_a, bus1.tt_b});
      end
      checks++;
      if ({dbg3, bus3.x, bus3.y, bus3.busy, bus3.done, bus3.equiv} !== {ST_IDLE, 8'h00}) begin
         failures++;
         $display("FAIL reset_ctrl3: got %b want %b", {dbg3, bus3.x, bus3.y, bus3.busy, bus3.done, bus3.equiv}, {ST_IDLE, 8'h00});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One SETTLE=1 sweep; start_mask bit k drives start into edge k.
   task automatic run_sweep1(input logic [35:0] want, input logic [15:0] start_mask, input string tag);
      logic [1:0] xy_exp;
      exp_q.push_back(want);
      bus1.start = start_mask[0];
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         bus1.start = start_mask[k+1];
         xy_exp = (k < 8) ? GRAY_ROWS[k/2] : 2'b00;
         checks++;
         if ({bus1.x, bus1.y} !== xy_exp) begin
            failures++;
            $display("FAIL %s xy_edge%0d: got %b want %b", tag, k, {bus1.x, bus1.y}, xy_exp);
         end
         checks++;
         if (bus1.busy !== (k < 8)) begin
            failures++;
            $display("FAIL %s busy_edge%0d: got %b want %b", tag, k, bus1.busy, (k < 8));
         end
         checks++;
         if (bus1.done !== (k == 8)) begin
            failures++;
            $display("FAIL %s done_edge%0d: got %b want %b", tag, k, bus1.done, (k == 8));
         end
         if (bus1.done === 1'b1) pop_and_compare({bus1.equiv, bus1.tt_a, bus1.tt_b}, tag);
      end
      checks++;
      if (dbg1 !== ST_IDLE) begin
         failures++;
         $display("FAIL %s idle_after: got %0d want %0d", tag, dbg1, ST_IDLE);
      end
      check_queue_empty(tag);
   endtask

   task automatic test_real_bank();
      bank_real = 1'b1;
      run_sweep1(REAL_EXP, 16'h0001, "real_bank");
   endtask

   task automatic test_stub_pairs();
      bank_real = 1'b0;
      run_sweep1(STUB_EXP, 16'h0001, "stub_pairs");
      bank_real = 1'b1;
   endtask

   task automatic test_start_ignored();
      run_sweep1(REAL_EXP, 16'h0025, "start_ignored");
   endtask

   task automatic test_abort();
      bus1.start = 1'b1;
      for (int k = 0; k <= 7; k++) begin
         @(negedge clk);
         bus1.start = (k == 2);
         bus1.abort = (k == 2);
         checks++;
         if (bus1.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_done_edge%0d: got %b want 0", k, bus1.done);
         end
         if (k < 3) begin
            checks++;
            if (bus1.busy !== 1'b1) begin
               failures++;
               $display("FAIL abort_busy_edge%0d: got %b want 1", k, bus1.busy);
            end
         end
         if (k == 3) begin
            checks++;
            if ({dbg1, bus1.x, bus1.y, bus1.busy} !== {ST_IDLE, 3'b000}) begin
               failures++;
               $display("FAIL abort_ctrl: got %b want %b", {dbg1, bus1.x, bus1.y, bus1.busy}, {ST_IDLE, 3'b000});
            end
            checks++;
            if ({bus1.equiv, bus1.tt_a, bus1.tt_b} !== 36'h0) begin
               failures++;
               $display("FAIL abort_results: got %h want 0", {bus1.equiv, bus1.tt_a, bus1.tt_b});
            end
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      bus1.start = 1'b1;
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         bus1.start = 1'b0;
         rst_n = (k != 4);
         checks++;
         if (bus1.done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_done_edge%0d: got %b want 0", k, bus1.done);
         end
         if (k == 5) begin
            checks++;
            if ({dbg1, bus1.x, bus1.y, bus1.busy, bus1.equiv} !== {ST_IDLE, 7'h00}) begin
               failures++;
               $display("FAIL rstmid_state: got %b want %b", {dbg1, bus1.x, bus1.y, bus1.busy, bus1.equiv}, {ST_IDLE, 7'h00});
            end
         end
      end
      rst_n = 1'b1;
   endtask

   // SETTLE=3 with start held through the first DONE.
   task automatic test_back_to_back();
      int j;
      logic [1:0] xy_exp;
      logic busy_exp;
      exp_q.push_back(REAL_EXP);
      exp_q.push_back(REAL_EXP);
      bus3.start = 1'b1;
      for (int k = 0; k <= 34; k++) begin
         @(negedge clk);
         bus3.start = (k + 1 <= 17);
         j = (k <= 16) ? k : k - 17;
         xy_exp = (j < 16) ? GRAY_ROWS[j/4] : 2'b00;
         busy_exp = (k < 16) || (k >= 17 && k < 33);
         checks++;
         if ({bus3.x, bus3.y} !== xy_exp) begin
            failures++;
            $display("FAIL b2b xy_edge%0d: got %b want %b", k, {bus3.x, bus3.y}, xy_exp);
         end
         checks++;
         if (bus3.busy !== busy_exp) begin
            failures++;
            $display("FAIL b2b busy_edge%0d: got %b want %b", k, bus3.busy, busy_exp);
         end
         checks++;
         if (bus3.done !== (k == 16 || k == 33)) begin
            failures++;
            $display("FAIL b2b done_edge%0d: got %b want %b", k, bus3.done, (k == 16 || k == 33));
         end
         if (k == 17) begin
            checks++;
            if (dbg3 !== ST_SETTLE) begin
               failures++;
               $display("FAIL b2b restart_state: got %0d want %0d", dbg3, ST_SETTLE);
            end
         end
         if (bus3.done === 1'b1) pop_and_compare({bus3.equiv, bus3.tt_a, bus3.tt_b}, "b2b");
      end
      check_queue_empty("b2b");
   endtask

   initial begin
      bus1.start = 1'b0;
      bus1.abort = 1'b0;
      bus3.start = 1'b0;
      bus3.abort = 1'b0;
      test_reset();
      test_real_bank();
      test_stub_pairs();
      test_start_ignored();
      test_abort();
      @(negedge clk);
      test_reset_mid_sweep();
      @(negedge clk);
      test_real_bank();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
